// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, default frame constants and parity helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_STOP_BITS    = 1;

  // XOR of the low nbits of data, inverted when odd parity is selected
  function automatic logic calc_parity(input logic [7:0] data, input int nbits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - bit-period counter with synchronous clear and end-of-bit tick
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  output logic bit_tick_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign bit_tick_o = (cnt_q == LAST) && !clear_i;

endmodule

// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit frame sequencer driving an external PISO
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = DEF_STOP_BITS
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       load_o,
  output logic       shift_o,
  input  logic       piso_out_i,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        load_q, load_d;
  logic        shift_q, shift_d;
  logic        done_q, done_d;
  logic        baud_clear;
  logic        bit_tick;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (baud_clear),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    tx_d       = tx_q;
    load_d     = 1'b0;
    shift_d    = 1'b0;
    done_d     = 1'b0;
    baud_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // counter held at zero so the start bit gets a full period from the handshake edge
        baud_clear = 1'b1;
        tx_d       = 1'b1;
        if (tx_valid_i) begin
          state_d   = ST_START;
          tx_d      = 1'b0;
          load_d    = 1'b1;
          data_d    = tx_data_i;
          bit_cnt_d = '0;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          state_d   = ST_DATA;
          tx_d      = piso_out_i;
          shift_d   = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = calc_parity(data_q, DATA_BITS, PARITY_ODD != 0);
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = piso_out_i;
            shift_d   = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          state_d   = ST_STOP;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_STOP: begin
        // bit_cnt is reused to count stop periods
        if (bit_tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      load_q    <= 1'b0;
      shift_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      load_q    <= load_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready_o = (state_q == ST_IDLE);
  assign busy_o     = (state_q != ST_IDLE);
  assign load_o     = load_q;
  assign shift_o    = shift_q;
  assign tx_o       = tx_q;
  assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - scoreboard bench for uart_tx_ctrl across parity and stop-bit configurations
module tb_uart_tx_ctrl;

  localparam int CPB  = 16;
  localparam int NDUT = 4;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  nbits;
    logic [7:0]  abort;
    logic        b2b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n    [NDUT];
  logic       tx_valid [NDUT];
  logic [7:0] tx_data  [NDUT];
  logic       tx_ready [NDUT];
  logic       load     [NDUT];
  logic       shift    [NDUT];
  logic       piso_out [NDUT];
  logic       tx       [NDUT];
  logic       busy     [NDUT];
  logic       done     [NDUT];

  exp_t exp_q [NDUT][$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2
  function automatic int cfg_pe(input int g);
    return (g == 1 || g == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_po(input int g);
    return (g == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(input int g);
    return (g == 3) ? 2 : 1;
  endfunction

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  // Line-level frame: start 0, data LSB first, optional parity, stop bits high
  function automatic exp_t model(input int g, input logic [7:0] d);
    exp_t e;
    int   n;
    logic par;
    e = '0;
    e.bits[0] = 1'b0;
    for (int k = 0; k < 8; k++) e.bits[1+k] = d[k];
    n = 9;
    if (cfg_pe(g) == 1) begin
      par = (($countones(d) % 2) == 1);
      if (cfg_po(g) == 1) par = ~par;
      e.bits[n] = par;
      n++;
    end
    for (int s = 0; s < cfg_sb(g); s++) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nbits = 5'(n);
    return e;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [7:0] piso_q = 8'h00;

    uart_tx_ctrl #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8),
      .PARITY_EN    (cfg_pe(g)),
      .PARITY_ODD   (cfg_po(g)),
      .STOP_BITS    (cfg_sb(g))
    ) u_dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n[g]),
      .tx_data_i  (tx_data[g]),
      .tx_valid_i (tx_valid[g]),
      .tx_ready_o (tx_ready[g]),
      .load_o     (load[g]),
      .shift_o    (shift[g]),
      .piso_out_i (piso_out[g]),
      .tx_o       (tx[g]),
      .busy_o     (busy[g]),
      .tx_done_o  (done[g])
    );

    always @(posedge clk) begin
      if (load[g] === 1'b1)       piso_q <= tx_data[g];
      else if (shift[g] === 1'b1) piso_q <= {1'b0, piso_q[7:1]};
    end
    assign piso_out[g] = piso_q[0];

    initial begin : monitor
      exp_t e;
      int idle, stray, match, bad_ctl, n_sh, len;
      bit aborted, exp_ld, exp_sh, exp_dn, exp_bz;
      forever begin
        idle  = 0;
        stray = 0;
        do begin
          @(negedge clk);
          idle++;
          if (done[g] === 1'b1) stray++;
        end while (load[g] !== 1'b1);
        check(stray == 0, $sformatf("dut%0d stray_done", g), stray, 0);
        if (exp_q[g].size() == 0) begin
          check(1'b0, $sformatf("dut%0d unexpected_frame", g), 1, 0);
        end else begin
          e       = exp_q[g].pop_front();
          len     = CPB * int'(e.nbits);
          match   = 0;
          bad_ctl = 0;
          n_sh    = 0;
          aborted = 1'b0;
          if (e.b2b) check(idle == 1, $sformatf("dut%0d b2b_gap", g), idle, 1);
          for (int c = 0; c <= len; c++) begin
            if (c > 0) @(negedge clk);
            if (e.abort != 0 && c == int'(e.abort)) begin
              check(tx[g] === 1'b1 && busy[g] === 1'b0 && done[g] === 1'b0,
                    $sformatf("dut%0d abort_state tx/busy/done", g),
                    int'({tx[g], busy[g], done[g]}), 4);
              aborted = 1'b1;
              break;
            end
            if (c < len) begin
              if (tx[g] === e.bits[c/CPB]) match++;
              if (c % CPB == CPB - 1) begin
                check(match == CPB, $sformatf("dut%0d tx_bit%0d cycles_correct", g, c/CPB), match, CPB);
                match = 0;
              end
            end else begin
              check(done[g] === 1'b1, $sformatf("dut%0d done_at_%0d", g, len), int'(done[g]), 1);
              check(tx[g] === 1'b1, $sformatf("dut%0d idle_high", g), int'(tx[g]), 1);
            end
            exp_ld = (c == 0);
            exp_sh = (c >= CPB && c <= 8 * CPB && c % CPB == 0);
            exp_dn = (c == len);
            exp_bz = (c < len);
            if (load[g] !== exp_ld || shift[g] !== exp_sh || done[g] !== exp_dn ||
                busy[g] !== exp_bz || tx_ready[g] !== !exp_bz) bad_ctl++;
            if (shift[g] === 1'b1) n_sh++;
          end
          check(bad_ctl == 0, $sformatf("dut%0d ctl_timing_bad_cycles", g), bad_ctl, 0);
          if (!aborted) check(n_sh == 8, $sformatf("dut%0d shift_count", g), n_sh, 8);
        end
      end
    end
  end

  task automatic wait_ready(input int g);
    int t;
    t = 0;
    while (tx_ready[g] !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check(tx_ready[g] === 1'b1, $sformatf("dut%0d ready_timeout", g), int'(tx_ready[g]), 1);
  endtask

  // Called at a negedge; returns at negedge index 1 of the frame (or at the abort point)
  task automatic send(input int g, input logic [7:0] d, input int abort, input bit noise);
    exp_t e;
    int   len;
    tx_data[g]  = d;
    tx_valid[g] = 1'b1;
    wait_ready(g);
    e       = model(g, d);
    e.abort = 8'(abort);
    exp_q[g].push_back(e);
    len = CPB * int'(e.nbits);
    @(posedge clk);
    @(negedge clk);
    tx_valid[g] = 1'b0;
    @(negedge clk);
    tx_data[g] = 8'($urandom);
    if (abort != 0) begin
      repeat (abort - 2) @(negedge clk);
      rst_n[g] = 1'b0;
      @(negedge clk);
      rst_n[g] = 1'b1;
    end else if (noise) begin
      for (int c = 2; c < len - 20; c++) begin
        @(negedge clk);
        tx_valid[g] = 1'($urandom_range(0, 1));
        tx_data[g]  = 8'($urandom);
      end
      tx_valid[g] = 1'b0;
    end
  endtask

  task automatic send_b2b(input int g, input logic [7:0] d1, input logic [7:0] d2);
    exp_t e;
    tx_data[g]  = d1;
    tx_valid[g] = 1'b1;
    wait_ready(g);
    exp_q[g].push_back(model(g, d1));
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    tx_data[g] = d2;
    @(negedge clk);
    wait_ready(g);
    e     = model(g, d2);
    e.b2b = 1'b1;
    exp_q[g].push_back(e);
    @(posedge clk);
    @(negedge clk);
    tx_valid[g] = 1'b0;
    @(negedge clk);
    tx_data[g] = 8'($urandom);
  endtask

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      rst_n[g]    = 1'b0;
      tx_valid[g] = 1'b0;
      tx_data[g]  = 8'h00;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check(tx[g] === 1'b1 && tx_ready[g] === 1'b1 && busy[g] === 1'b0,
            $sformatf("dut%0d reset tx/ready/busy", g), int'({tx[g], tx_ready[g], busy[g]}), 6);
      check(load[g] === 1'b0 && shift[g] === 1'b0 && done[g] === 1'b0,
            $sformatf("dut%0d reset load/shift/done", g), int'({load[g], shift[g], done[g]}), 0);
      rst_n[g] = 1'b1;
    end
    repeat (4) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check(tx[g] === 1'b1 && tx_ready[g] === 1'b1 && busy[g] === 1'b0 &&
            load[g] === 1'b0 && shift[g] === 1'b0 && done[g] === 1'b0,
            $sformatf("dut%0d post_reset_idle", g),
            int'({tx[g], tx_ready[g], busy[g], load[g], shift[g], done[g]}), 48);
    end

    for (int g = 0; g < NDUT; g++) begin
      send(g, 8'hA5, 0, 1'b0);
      wait_ready(g);
      send(g, 8'h07, 0, 1'b0);
      wait_ready(g);
      send_b2b(g, 8'h55, 8'hAA);
      wait_ready(g);
      for (int i = 0; i < 3; i++) begin
        send(g, 8'($urandom), 0, 1'b1);
        wait_ready(g);
      end
      if (g == 0) begin
        send(g, 8'($urandom), CPB * 4 + int'($urandom_range(0, CPB - 1)), 1'b0);
        send(g, 8'h3C, 0, 1'b0);
        wait_ready(g);
      end
    end

    repeat (5) @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check(exp_q[g].size() == 0, $sformatf("dut%0d frames_pending", g), exp_q[g].size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
